bsg_zynq_axil_fifo_arbiter: RTL and testbench

//  Shares one bsg_axil_fifo_master command/response port among num_clients_p requesters.

---
 rtl/bsg_zynq_axil_arb_pkg.sv | 25 ++
 rtl/bsg_fifo_1r1w_small.sv | 52 +++++
 rtl/bsg_zynq_axil_fifo_arbiter.sv | 151 +++++++++++++++
 tb/tb_bsg_zynq_axil_fifo_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_zynq_axil_arb_pkg.sv
// Shared types and constants for the AXI-Lite fifo-master arbiter.
// The command struct is sized from the package default widths.
// The top's width parameters default to these same values.

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package bsg_zynq_axil_arb_pkg;

  localparam int arb_num_clients_lp = 2;
  localparam int arb_data_width_lp  = 32;
  localparam int arb_addr_width_lp  = 32;

  // Requester-ID width for the default client count
  localparam int lg_clients_lp = `BSG_SAFE_CLOG2(arb_num_clients_lp);

  typedef struct packed {
    logic [arb_data_width_lp-1:0]   data;
    logic [arb_addr_width_lp-1:0]   addr;
    logic                           w;
    logic [arb_data_width_lp/8-1:0] wmask;
  } bsg_zynq_axil_cmd_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO used to hold requester tags in issue order.
// ready_o is derived only from stored occupancy. A pop in the same cycle
// does not open a slot for a push (no bypass).

module bsg_fifo_1r1w_small #(
  parameter int width_p = 1,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p <= 1) ? 1 : $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_rd, r_wr;
  logic [cnt_w_lp-1:0] r_cnt;
  logic                w_push, w_pop;

  assign ready_o = (r_cnt != cnt_w_lp'(els_p));
  assign v_o     = (r_cnt != '0);
  assign data_o  = r_mem[r_rd];
  assign w_push  = v_i & ready_o;
  assign w_pop   = yumi_i & v_o;

  // Storage write; contents need no reset because occupancy gates reads
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= data_i;
  end

  // Read/write pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == ptr_w_lp'(els_p - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == ptr_w_lp'(els_p - 1)) ? '0 : r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/bsg_zynq_axil_fifo_arbiter.sv
// Round-robin arbiter sharing one fifo-master command/response port among
// several clients. Requester IDs are queued in issue order so each response
// is routed back to the client that sent the command.
// Optional feature macro: BSG_ZYNQ_AXIL_ARB_LOCK_EN (grant lock via cl_lock_i).

module bsg_zynq_axil_fifo_arbiter
  import bsg_zynq_axil_arb_pkg::*;
#(
  parameter int num_clients_p     = arb_num_clients_lp,
  parameter int axil_data_width_p = arb_data_width_lp,
  parameter int axil_addr_width_p = arb_addr_width_lp,
  parameter int max_outstanding_p = 4
) (
  input  logic                                                  clk_i,
  input  logic                                                  reset_i,
  input  logic [num_clients_p-1:0][axil_data_width_p-1:0]       cl_data_i,
  input  logic [num_clients_p-1:0][axil_addr_width_p-1:0]       cl_addr_i,
  input  logic [num_clients_p-1:0]                              cl_v_i,
  input  logic [num_clients_p-1:0]                              cl_w_i,
  input  logic [num_clients_p-1:0][axil_data_width_p/8-1:0]     cl_wmask_i,
  input  logic [num_clients_p-1:0]                              cl_lock_i,
  output logic [num_clients_p-1:0]                              cl_ready_and_o,
  output logic [axil_data_width_p-1:0]                          cl_data_o,
  output logic [num_clients_p-1:0]                              cl_v_o,
  input  logic [num_clients_p-1:0]                              cl_ready_and_i,
  output logic [axil_data_width_p-1:0]                          m_data_o,
  output logic [axil_addr_width_p-1:0]                          m_addr_o,
  output logic                                                  m_v_o,
  output logic                                                  m_w_o,
  output logic [axil_data_width_p/8-1:0]                        m_wmask_o,
  input  logic                                                  m_ready_and_i,
  input  logic [axil_data_width_p-1:0]                          m_data_i,
  input  logic                                                  m_v_i,
  output logic                                                  m_ready_and_o
);

  // Tag width follows the actual client count of this instance
  localparam int tag_w_lp = `BSG_SAFE_CLOG2(num_clients_p);

  logic [tag_w_lp-1:0]      r_ptr;
  logic [num_clients_p-1:0] w_eligible, w_req_rot;
  logic                     w_found, w_grant_v, w_accept, w_advance;
  logic [tag_w_lp-1:0]      w_offset, w_gnt_id, w_next_ptr;
  logic [tag_w_lp:0]        w_sum;
  logic                     w_fifo_ready, w_full, w_tag_v, w_pop;
  logic [tag_w_lp-1:0]      w_head;

  bsg_zynq_axil_cmd_s [num_clients_p-1:0] w_cmd;
  bsg_zynq_axil_cmd_s                     w_cmd_sel;

  for (genvar gi = 0; gi < num_clients_p; gi++) begin : g_cmd
    assign w_cmd[gi] = '{data: cl_data_i[gi], addr: cl_addr_i[gi],
                         w: cl_w_i[gi], wmask: cl_wmask_i[gi]};
  end

`ifdef BSG_ZYNQ_AXIL_ARB_LOCK_EN
  logic                r_lock;
  logic [tag_w_lp-1:0] r_owner;

  // While locked, only the owner may compete for the port
  always_comb begin
    w_eligible = cl_v_i;
    if (r_lock) w_eligible = cl_v_i & (num_clients_p'(1) << r_owner);
  end

  // A locking command keeps the pointer on its issuer
  assign w_advance = ~cl_lock_i[w_gnt_id];

  // Lock latch: set by an accepted lock=1 command, cleared by its lock=0 one
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_lock  <= 1'b0;
      r_owner <= '0;
    end else if (w_accept) begin
      r_lock  <= cl_lock_i[w_gnt_id];
      r_owner <= w_gnt_id;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^cl_lock_i;
  assign w_eligible    = cl_v_i;
  assign w_advance     = 1'b1;
`endif

  // Rotate requests so bit 0 is the client at the rr pointer
  assign w_req_rot = num_clients_p'({w_eligible, w_eligible} >> r_ptr);

  // First requester at or after the pointer wins
  always_comb begin
    w_found  = 1'b0;
    w_offset = '0;
    for (int i = 0; i < num_clients_p; i++) begin
      if (!w_found && w_req_rot[i]) begin
        w_found  = 1'b1;
        w_offset = tag_w_lp'(i);
      end
    end
  end

  assign w_sum      = {1'b0, r_ptr} + {1'b0, w_offset};
  assign w_gnt_id   = (w_sum >= (tag_w_lp+1)'(num_clients_p))
                      ? tag_w_lp'(w_sum - (tag_w_lp+1)'(num_clients_p))
                      : tag_w_lp'(w_sum);
  assign w_next_ptr = (w_gnt_id == tag_w_lp'(num_clients_p - 1)) ? '0 : w_gnt_id + 1'b1;

  assign w_full    = ~w_fifo_ready;
  assign w_grant_v = w_found & ~w_full & ~reset_i;
  assign w_accept  = w_grant_v & m_ready_and_i;

  assign w_cmd_sel      = w_cmd[w_gnt_id];
  assign m_v_o          = w_grant_v;
  assign m_data_o       = w_cmd_sel.data;
  assign m_addr_o       = w_cmd_sel.addr;
  assign m_w_o          = w_cmd_sel.w;
  assign m_wmask_o      = w_cmd_sel.wmask;
  assign cl_ready_and_o = w_accept ? (num_clients_p'(1) << w_gnt_id) : '0;

  // Round-robin pointer moves past the winner only on a completed handshake
  always_ff @(posedge clk_i) begin
    if (reset_i)                      r_ptr <= '0;
    else if (w_accept && w_advance)   r_ptr <= w_next_ptr;
  end

  bsg_fifo_1r1w_small #(
    .width_p (tag_w_lp),
    .els_p   (max_outstanding_p)
  ) tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (w_accept),
    .ready_o (w_fifo_ready),
    .data_i  (w_gnt_id),
    .v_o     (w_tag_v),
    .data_o  (w_head),
    .yumi_i  (w_pop)
  );

  // Responses go strictly to the oldest outstanding issuer
  assign cl_data_o     = m_data_i;
  assign cl_v_o        = (m_v_i & w_tag_v & ~reset_i) ? (num_clients_p'(1) << w_head) : '0;
  assign m_ready_and_o = w_tag_v & cl_ready_and_i[w_head] & ~reset_i;
  assign w_pop         = m_v_i & m_ready_and_o;

`ifndef SYNTHESIS
  // A response with no outstanding command means the master misbehaved
  a_no_orphan_resp: assert property (@(posedge clk_i) disable iff (reset_i)
    !(m_v_i && !w_tag_v));
`endif

endmodule

// File: tb/tb_bsg_zynq_axil_fifo_arbiter.sv
// Self-checking bench for bsg_zynq_axil_fifo_arbiter (2 clients, depth 4).
// Expected issuer IDs are queued as commands are driven and popped as
// responses are delivered. Honors BSG_ZYNQ_AXIL_ARB_LOCK_EN when defined.

module tb_bsg_zynq_axil_fifo_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = DW / 8;
  localparam int MO = 4;

  logic                 clk_i = 1'b0;
  logic                 reset_i;
  logic [N-1:0][DW-1:0] cl_data_i;
  logic [N-1:0][AW-1:0] cl_addr_i;
  logic [N-1:0]         cl_v_i, cl_w_i, cl_lock_i, cl_ready_and_o, cl_v_o, cl_ready_and_i;
  logic [N-1:0][MW-1:0] cl_wmask_i;
  logic [DW-1:0]        cl_data_o, m_data_o, m_data_i;
  logic [AW-1:0]        m_addr_o;
  logic                 m_v_o, m_w_o, m_ready_and_i, m_v_i, m_ready_and_o;
  logic [MW-1:0]        m_wmask_o;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  always #5 clk_i = ~clk_i;

  bsg_zynq_axil_fifo_arbiter #(
    .num_clients_p(N), .axil_data_width_p(DW), .axil_addr_width_p(AW),
    .max_outstanding_p(MO)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cl_data_i(cl_data_i), .cl_addr_i(cl_addr_i), .cl_v_i(cl_v_i), .cl_w_i(cl_w_i),
    .cl_wmask_i(cl_wmask_i), .cl_lock_i(cl_lock_i), .cl_ready_and_o(cl_ready_and_o),
    .cl_data_o(cl_data_o), .cl_v_o(cl_v_o), .cl_ready_and_i(cl_ready_and_i),
    .m_data_o(m_data_o), .m_addr_o(m_addr_o), .m_v_o(m_v_o), .m_w_o(m_w_o),
    .m_wmask_o(m_wmask_o), .m_ready_and_i(m_ready_and_i), .m_data_i(m_data_i),
    .m_v_i(m_v_i), .m_ready_and_o(m_ready_and_o)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  function automatic logic [N-1:0] head_oh();
    logic [N-1:0] r;
    r = '0;
    if (exp_q.size() > 0) r = N'(1) << exp_q[0];
    return r;
  endfunction

  task automatic sb_pop();
    int h;
    if (exp_q.size() > 0) h = exp_q.pop_front();
  endtask

  task automatic idle_inputs();
    cl_data_i = '0; cl_addr_i = '0; cl_v_i = '0; cl_w_i = '0; cl_wmask_i = '0;
    cl_lock_i = '0; cl_ready_and_i = '0; m_ready_and_i = 1'b0; m_data_i = '0; m_v_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    idle_inputs();
    next_cycle();
    reset_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1'b1;
    cl_v_i = 2'b11; m_ready_and_i = 1'b1; m_v_i = 1'b1; cl_ready_and_i = 2'b11;
    @(negedge clk_i);
    tests++; if (cl_ready_and_o !== 2'b00) begin fails++; $display("FAIL reset_cl_ready: got %b want 00", cl_ready_and_o); end
    tests++; if (cl_v_o !== 2'b00) begin fails++; $display("FAIL reset_cl_v: got %b want 00", cl_v_o); end
    tests++; if (m_v_o !== 1'b0) begin fails++; $display("FAIL reset_m_v: got %b want 0", m_v_o); end
    tests++; if (m_ready_and_o !== 1'b0) begin fails++; $display("FAIL reset_m_ready: got %b want 0", m_ready_and_o); end
    next_cycle();
    reset_i = 1'b0;
    idle_inputs();
    exp_q.delete();
  endtask

  task automatic test_single_read();
    cl_v_i = 2'b01; cl_addr_i[0] = 32'h8; cl_w_i = 2'b00; m_ready_and_i = 1'b1;
    @(negedge clk_i);
    tests++; if (cl_ready_and_o !== 2'b01) begin fails++; $display("FAIL single_accept: got %b want 01", cl_ready_and_o); end
    tests++; if (m_v_o !== 1'b1 || m_addr_o !== 32'h8 || m_w_o !== 1'b0) begin
      fails++; $display("FAIL single_cmd: got v=%b addr=%h w=%b want v=1 addr=8 w=0", m_v_o, m_addr_o, m_w_o); end
    exp_q.push_back(0);
    next_cycle();
    cl_v_i = 2'b00; m_v_i = 1'b1; m_data_i = 32'h1; cl_ready_and_i = 2'b11;
    @(negedge clk_i);
    tests++; if (cl_v_o !== 2'b01 || cl_v_o !== head_oh()) begin fails++; $display("FAIL single_route: got %b want 01", cl_v_o); end
    tests++; if (cl_data_o !== 32'h1) begin fails++; $display("FAIL single_data: got %h want 1", cl_data_o); end
    tests++; if (m_ready_and_o !== 1'b1) begin fails++; $display("FAIL single_m_ready: got %b want 1", m_ready_and_o); end
    sb_pop();
    next_cycle();
    m_v_i = 1'b0;
    @(negedge clk_i);
    tests++; if (m_ready_and_o !== 1'b0) begin fails++; $display("FAIL single_empty: got m_ready_and_o=%b want 0", m_ready_and_o); end
    next_cycle();
  endtask

  task automatic test_rr_alternate();
    int k0, k1, g;
    do_reset();
    k0 = 0; k1 = 0;
    cl_w_i = 2'b10; cl_wmask_i[1] = 4'hA; m_ready_and_i = 1'b1; cl_ready_and_i = 2'b11;
    for (int cyc = 0; cyc < 8; cyc++) begin
      cl_v_i[0] = (k0 < 4); cl_v_i[1] = (k1 < 4);
      cl_addr_i[0] = 32'h100 + k0; cl_addr_i[1] = 32'h200 + k1;
      cl_data_i[1] = 32'hC0DE_0000 + k1;
      m_v_i = (cyc > 0); m_data_i = 32'hD000 + cyc;
      g = cyc % 2;
      @(negedge clk_i);
      tests++; if (cl_ready_and_o !== (2'b01 << g)) begin
        fails++; $display("FAIL rr_grant cyc%0d: got %b want %b", cyc, cl_ready_and_o, 2'b01 << g); end
      tests++; if (m_addr_o !== ((g == 1) ? 32'h200 + k1 : 32'h100 + k0) || m_w_o !== g[0]) begin
        fails++; $display("FAIL rr_cmd cyc%0d: got addr=%h w=%b", cyc, m_addr_o, m_w_o); end
      if (g == 1) begin
        tests++; if (m_data_o !== 32'hC0DE_0000 + k1 || m_wmask_o !== 4'hA) begin
          fails++; $display("FAIL rr_wdata cyc%0d: got %h/%h want %h/a", cyc, m_data_o, m_wmask_o, 32'hC0DE_0000 + k1); end
      end
      if (m_v_i) begin
        tests++; if (cl_v_o !== head_oh() || cl_data_o !== 32'hD000 + cyc) begin
          fails++; $display("FAIL rr_resp cyc%0d: got %b/%h want %b", cyc, cl_v_o, cl_data_o, head_oh()); end
        sb_pop();
      end
      exp_q.push_back(g);
      if (g == 1) k1++; else k0++;
      next_cycle();
    end
    cl_v_i = 2'b00; m_v_i = 1'b1;
    @(negedge clk_i);
    tests++; if (cl_v_o !== 2'b10 || cl_v_o !== head_oh()) begin fails++; $display("FAIL rr_last_resp: got %b want 10", cl_v_o); end
    sb_pop();
    next_cycle();
    m_v_i = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    cl_v_i = 2'b01; m_ready_and_i = 1'b1; cl_ready_and_i = 2'b01;
    for (int i = 0; i < MO; i++) begin
      cl_addr_i[0] = 32'(i * 4);
      @(negedge clk_i);
      tests++; if (cl_ready_and_o !== 2'b01) begin fails++; $display("FAIL full_fill%0d: got %b want 01", i, cl_ready_and_o); end
      exp_q.push_back(0);
      next_cycle();
    end
    @(negedge clk_i);
    tests++; if (cl_ready_and_o !== 2'b00 || m_v_o !== 1'b0) begin
      fail_full_block: fails++; $display("FAIL full_block: got ready=%b m_v=%b want 00/0", cl_ready_and_o, m_v_o); end
    next_cycle();
    m_v_i = 1'b1; m_data_i = 32'h55;
    @(negedge clk_i);
    tests++; if (cl_ready_and_o !== 2'b00) begin fails++; $display("FAIL full_no_bypass: got %b want 00", cl_ready_and_o); end
    tests++; if (cl_v_o !== head_oh() || m_ready_and_o !== 1'b1) begin
      fails++; $display("FAIL full_pop: got cl_v=%b m_ready=%b want %b/1", cl_v_o, m_ready_and_o, head_oh()); end
    sb_pop();
    next_cycle();
    m_v_i = 1'b0;
    @(negedge clk_i);
    tests++; if (cl_ready_and_o !== 2'b01) begin fails++; $display("FAIL full_refill: got %b want 01", cl_ready_and_o); end
    exp_q.push_back(0);
    next_cycle();
    cl_v_i = 2'b00; m_v_i = 1'b1;
    for (int i = 0; i < MO; i++) begin
      m_data_i = 32'h60 + i;
      @(negedge clk_i);
      tests++; if (cl_v_o !== head_oh() || cl_data_o !== 32'h60 + i) begin
        fails++; $display("FAIL full_drain%0d: got %b/%h want %b", i, cl_v_o, cl_data_o, head_oh()); end
      sb_pop();
      next_cycle();
    end
    m_v_i = 1'b0;
  endtask

  task automatic test_head_of_line();
    do_reset();
    m_ready_and_i = 1'b1; cl_ready_and_i = 2'b00;
    cl_v_i = 2'b10; cl_addr_i[1] = 32'h40;
    @(negedge clk_i);
    tests++; if (cl_ready_and_o !== 2'b10) begin fails++; $display("FAIL hol_issue1: got %b want 10", cl_ready_and_o); end
    exp_q.push_back(1);
    next_cycle();
    cl_v_i = 2'b01; cl_addr_i[0] = 32'h44;
    @(negedge clk_i);
    tests++; if (cl_ready_and_o !== 2'b01) begin fails++; $display("FAIL hol_issue0: got %b want 01", cl_ready_and_o); end
    exp_q.push_back(0);
    next_cycle();
    cl_v_i = 2'b00; m_v_i = 1'b1; m_data_i = 32'hAA; cl_ready_and_i = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      tests++; if (m_ready_and_o !== 1'b0 || cl_v_o !== 2'b10) begin
        fails++; $display("FAIL hol_stall%0d: got m_ready=%b cl_v=%b want 0/10", i, m_ready_and_o, cl_v_o); end
      next_cycle();
    end
    cl_ready_and_i = 2'b11;
    @(negedge clk_i);
    tests++; if (m_ready_and_o !== 1'b1 || cl_v_o !== head_oh()) begin
      fails++; $display("FAIL hol_release: got m_ready=%b cl_v=%b want 1/%b", m_ready_and_o, cl_v_o, head_oh()); end
    sb_pop();
    next_cycle();
    m_data_i = 32'hBB;
    @(negedge clk_i);
    tests++; if (cl_v_o !== 2'b01 || cl_data_o !== 32'hBB) begin
      fails++; $display("FAIL hol_second: got %b/%h want 01/bb", cl_v_o, cl_data_o); end
    sb_pop();
    next_cycle();
    m_v_i = 1'b0;
  endtask

  task automatic test_lock();
    int seq[3];
    int k0;
    bit c1_done;
`ifdef BSG_ZYNQ_AXIL_ARB_LOCK_EN
    seq = '{0, 0, 1};
`else
    seq = '{0, 1, 0};
`endif
    do_reset();
    k0 = 0; c1_done = 1'b0;
    m_ready_and_i = 1'b1; cl_ready_and_i = 2'b11; cl_addr_i[1] = 32'h300;
    for (int cyc = 0; cyc < 3; cyc++) begin
      cl_v_i[0] = (k0 < 2); cl_v_i[1] = !c1_done;
      cl_addr_i[0] = (k0 == 0) ? 32'h8 : 32'h0;
      cl_lock_i[0] = (k0 == 0);
      @(negedge clk_i);
      tests++; if (cl_ready_and_o !== (2'b01 << seq[cyc])) begin
        fails++; $display("FAIL lock_grant cyc%0d: got %b want %b", cyc, cl_ready_and_o, 2'b01 << seq[cyc]); end
      exp_q.push_back(seq[cyc]);
      if (seq[cyc] == 0) k0++; else c1_done = 1'b1;
      next_cycle();
    end
    cl_v_i = 2'b00; cl_lock_i = 2'b00; m_v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      tests++; if (cl_v_o !== head_oh()) begin fails++; $display("FAIL lock_resp%0d: got %b want %b", i, cl_v_o, head_oh()); end
      sb_pop();
      next_cycle();
    end
    m_v_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    cl_v_i = 2'b01; m_ready_and_i = 1'b1; cl_ready_and_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      tests++; if (cl_ready_and_o !== 2'b01) begin fails++; $display("FAIL rmid_issue%0d: got %b want 01", i, cl_ready_and_o); end
      exp_q.push_back(0);
      next_cycle();
    end
    reset_i = 1'b1; cl_v_i = 2'b11; m_v_i = 1'b1; m_data_i = 32'h77;
    @(negedge clk_i);
    tests++; if (cl_ready_and_o !== 2'b00 || cl_v_o !== 2'b00 || m_v_o !== 1'b0 || m_ready_and_o !== 1'b0) begin
      fails++; $display("FAIL rmid_outputs: got rdy=%b clv=%b mv=%b mrdy=%b want all 0", cl_ready_and_o, cl_v_o, m_v_o, m_ready_and_o); end
    next_cycle();
    reset_i = 1'b0; m_v_i = 1'b0; exp_q.delete();
    cl_addr_i[0] = 32'hC0; cl_addr_i[1] = 32'hC4;
    @(negedge clk_i);
    tests++; if (m_ready_and_o !== 1'b0) begin fails++; $display("FAIL rmid_flushed: got m_ready=%b want 0", m_ready_and_o); end
    tests++; if (cl_ready_and_o !== 2'b01 || m_addr_o !== 32'hC0) begin
      fails++; $display("FAIL rmid_ptr: got %b addr=%h want 01 addr=c0", cl_ready_and_o, m_addr_o); end
    exp_q.push_back(0);
    next_cycle();
    cl_v_i = 2'b00; m_v_i = 1'b1; m_data_i = 32'h99;
    @(negedge clk_i);
    tests++; if (cl_v_o !== head_oh() || cl_v_o !== 2'b01) begin fails++; $display("FAIL rmid_resp: got %b want 01", cl_v_o); end
    sb_pop();
    next_cycle();
    m_v_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_rr_alternate();
    test_full();
    test_head_of_line();
    test_lock();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
